// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS core.
//   Resolves branch/jump redirects, runs data-memory accesses over a
//   req/ack handshake (stalling upstream while busy), and holds the
//   MEM/WB pipeline register.
// Optional: define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES
//   BUSY cycles without ack (sets sticky mem_error).
// Ports:
//   clk, rst (async, active-low)
//   EX_MEM inputs: RegWrite_in, MemtoReg_in, Branch_in, MemRead_in,
//     MemWrite_in, Jump_in, jump_addr_in, branch_addr_in, ALU_zero_in,
//     ALU_result_in, reg_read_data_2_in, EX_MEM_RegisterRd_in
//   pc_redirect, pc_target : combinational redirect
//   mem_stall              : freezes upstream stages
//   dmem_req/we/addr/wdata, dmem_ack/rdata : data memory handshake
//   RegWrite_out, MemtoReg_out, read_data_out, ALU_result_out,
//   MEM_WB_RegisterRd_out  : MEM/WB register
//   mem_error              : sticky timeout flag
module mem_stage #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned RD_W           = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              Branch_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              Jump_in,
  input  logic [DATA_W-1:0] jump_addr_in,
  input  logic [DATA_W-1:0] branch_addr_in,
  input  logic              ALU_zero_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] reg_read_data_2_in,
  input  logic [RD_W-1:0]   EX_MEM_RegisterRd_in,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] pc_target,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] ALU_result_out,
  output logic [RD_W-1:0]   MEM_WB_RegisterRd_out,
  output logic              mem_error
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic                access;
  logic                req_d, we_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                rw_d, mtr_d;
  logic [RD_W-1:0]     rd_d;
  logic [DATA_W-1:0]   alu_d, rdata_d;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d;
`endif

  assign access = MemRead_in | MemWrite_in;

  // Redirect is independent of stall; the hazard unit qualifies it.
  assign pc_redirect = (Branch_in & ALU_zero_in) | Jump_in;
  assign pc_target   = Jump_in ? jump_addr_in : branch_addr_in;

  // Upstream is frozen while BUSY, so these stay stable for the access.
  assign dmem_addr  = {ALU_result_in[DATA_W-1:2], 2'b00};
  assign dmem_wdata = reg_read_data_2_in;

  // Gated by reset so an in-reset access request cannot freeze upstream.
  assign mem_stall = rst & ((state_q == BUSY) | ((state_q == IDLE) & access));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and next register values; MEM/WB defaults to a bubble
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    we_d    = dmem_we;
    hold_d  = hold_q;
    rw_d    = 1'b0;
    mtr_d   = 1'b0;
    rd_d    = '0;
    alu_d   = '0;
    rdata_d = '0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = mem_error;
`endif
    case (state_q)
      IDLE: begin
        if (access) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = MemWrite_in;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          rw_d  = RegWrite_in;
          mtr_d = MemtoReg_in;
          rd_d  = EX_MEM_RegisterRd_in;
          alu_d = ALU_result_in;
        end
      end
      BUSY: begin
        req_d = 1'b1;
        if (dmem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          hold_d  = dmem_we ? '0 : dmem_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          hold_d  = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        rw_d    = RegWrite_in;
        mtr_d   = MemtoReg_in;
        rd_d    = EX_MEM_RegisterRd_in;
        alu_d   = ALU_result_in;
        rdata_d = hold_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake, hold and MEM/WB registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req              <= 1'b0;
      dmem_we               <= 1'b0;
      hold_q                <= '0;
      RegWrite_out          <= 1'b0;
      MemtoReg_out          <= 1'b0;
      MEM_WB_RegisterRd_out <= '0;
      ALU_result_out        <= '0;
      read_data_out         <= '0;
    end else begin
      dmem_req              <= req_d;
      dmem_we               <= we_d;
      hold_q                <= hold_d;
      RegWrite_out          <= rw_d;
      MemtoReg_out          <= mtr_d;
      MEM_WB_RegisterRd_out <= rd_d;
      ALU_result_out        <= alu_d;
      read_data_out         <= rdata_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Timeout counter and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      mem_error <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_error <= err_d;
    end
  end
`else
  assign mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage. Stimulus pushes the
// expected MEM/WB contents; a negedge monitor pops and compares whenever the
// MEM/WB register holds a non-bubble instruction.
module tb_mem_stage;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Jump_in;
  logic [31:0] jump_addr_in, branch_addr_in, ALU_result_in, reg_read_data_2_in;
  logic        ALU_zero_in;
  logic [4:0]  EX_MEM_RegisterRd_in;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        RegWrite_out, MemtoReg_out;
  logic [31:0] read_data_out, ALU_result_out;
  logic [4:0]  MEM_WB_RegisterRd_out;
  logic        mem_error;

  int errors = 0;
  int checks = 0;
  wb_t exp_q[$];

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(32), .RD_W(5), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Jump_in(Jump_in),
    .jump_addr_in(jump_addr_in), .branch_addr_in(branch_addr_in),
    .ALU_zero_in(ALU_zero_in), .ALU_result_in(ALU_result_in),
    .reg_read_data_2_in(reg_read_data_2_in), .EX_MEM_RegisterRd_in(EX_MEM_RegisterRd_in),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .read_data_out(read_data_out), .ALU_result_out(ALU_result_out),
    .MEM_WB_RegisterRd_out(MEM_WB_RegisterRd_out), .mem_error(mem_error)
  );

  // Monitor: every non-bubble MEM/WB value must match the next expectation
  always @(negedge clk) begin
    wb_t act;
    wb_t exp;
    act = {RegWrite_out, MemtoReg_out, MEM_WB_RegisterRd_out, ALU_result_out, read_data_out};
    if (rst === 1'b1 && act !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got %h expected none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL wb_entry: got %h expected %h", act, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear();
    RegWrite_in = 0; MemtoReg_in = 0; Branch_in = 0; MemRead_in = 0; MemWrite_in = 0;
    Jump_in = 0; jump_addr_in = 0; branch_addr_in = 0; ALU_zero_in = 0;
    ALU_result_in = 0; reg_read_data_2_in = 0; EX_MEM_RegisterRd_in = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  // One memory instruction: busy_n BUSY cycles, ack on the last one if give_ack
  task automatic run_access(input logic rdf, input logic wrf, input logic rw, input logic mtr,
                            input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int busy_n, input logic give_ack,
                            input logic [31:0] exp_rdata);
    wb_t e;
    logic [31:0] exp_addr;
    RegWrite_in = rw; MemtoReg_in = mtr; MemRead_in = rdf; MemWrite_in = wrf;
    EX_MEM_RegisterRd_in = rd; ALU_result_in = alu; reg_read_data_2_in = wdata;
    dmem_rdata = rdata; dmem_ack = 0;
    e = {rw, mtr, rd, alu, exp_rdata};
    exp_q.push_back(e);
    exp_addr = {alu[31:2], 2'b00};
    sample();
    chk("idle_stall", 32'(mem_stall), 1);
    chk("idle_req", 32'(dmem_req), 0);
    for (int i = 1; i <= busy_n; i++) begin
      cyc();
      if (i == busy_n && give_ack) dmem_ack = 1;
      sample();
      chk("busy_req", 32'(dmem_req), 1);
      chk("busy_stall", 32'(mem_stall), 1);
      chk("busy_we", 32'(dmem_we), 32'(wrf));
      chk("busy_addr", dmem_addr, exp_addr);
      chk("busy_wdata", dmem_wdata, wdata);
    end
    cyc();
    dmem_ack = 0;
    sample();
    chk("done_req", 32'(dmem_req), 0);
    chk("done_stall", 32'(mem_stall), 0);
    cyc();
    clear();
  endtask

  initial begin
    rst = 0;
    clear();
    sample();
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(mem_stall), 0);
    chk("rst_we", 32'(dmem_we), 0);
    chk("rst_wb", {31'b0, RegWrite_out | MemtoReg_out} | ALU_result_out | read_data_out, 0);
    chk("rst_err", 32'(mem_error), 0);
    cyc();
    rst = 1;
    sample();
    chk("idle_req", 32'(dmem_req), 0);

    // ALU op passes straight through in one cycle
    cyc();
    RegWrite_in = 1; ALU_result_in = 32'h0000_1234; EX_MEM_RegisterRd_in = 5;
    exp_q.push_back({1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'h0});
    sample();
    chk("alu_stall", 32'(mem_stall), 0);
    cyc();
    clear();
    sample();
    chk("alu_stall2", 32'(mem_stall), 0);

    // Redirects
    cyc();
    Branch_in = 1; ALU_zero_in = 1; branch_addr_in = 32'h40; jump_addr_in = 32'h80;
    sample();
    chk("br_taken", 32'(pc_redirect), 1);
    chk("br_target", pc_target, 32'h40);
    cyc();
    ALU_zero_in = 0;
    sample();
    chk("br_not_taken", 32'(pc_redirect), 0);
    cyc();
    Jump_in = 1;
    sample();
    chk("jmp_redirect", 32'(pc_redirect), 1);
    chk("jmp_target", pc_target, 32'h80);
    cyc();
    ALU_zero_in = 1;
    sample();
    chk("jmp_target_z", pc_target, 32'h80);
    cyc();
    clear();

    // Stray ack with no access
    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    sample();
    chk("stray_req", 32'(dmem_req), 0);
    cyc();
    sample();
    chk("stray_req2", 32'(dmem_req), 0);
    chk("stray_stall", 32'(mem_stall), 0);
    cyc();
    clear();

    // Load, ack on 3rd BUSY cycle
    run_access(1, 0, 1, 1, 5'd7, 32'h0000_0103, 32'h0, 32'hCAFE_F00D, 3, 1, 32'hCAFE_F00D);
    // Store, immediate ack; rdata must not be captured
    run_access(0, 1, 0, 0, 5'd9, 32'h0000_0200, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1, 1, 32'h0);
    // Read and write together behave as a write
    run_access(1, 1, 1, 1, 5'd10, 32'h0000_0304, 32'h1357_9BDF, 32'h2468_ACE0, 2, 1, 32'h0);
    // Back-to-back loads
    run_access(1, 0, 1, 1, 5'd11, 32'h0000_0404, 32'h0, 32'h1111_2222, 1, 1, 32'h1111_2222);
    run_access(1, 0, 1, 1, 5'd12, 32'h0000_0408, 32'h0, 32'h3333_4444, 2, 1, 32'h3333_4444);
    sample();

    // Reset in the middle of BUSY
    cyc();
    MemRead_in = 1; RegWrite_in = 1; ALU_result_in = 32'h0000_0500; EX_MEM_RegisterRd_in = 13;
    cyc();
    sample();
    chk("pre_rst_req", 32'(dmem_req), 1);
    #2;
    rst = 0;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 0);
    chk("mid_rst_stall", 32'(mem_stall), 0);
    chk("mid_rst_wb", {31'b0, RegWrite_out | MemtoReg_out} | ALU_result_out | read_data_out, 0);
    dmem_ack = 1; dmem_rdata = 32'h5555_AAAA;
    cyc();
    MemRead_in = 0; RegWrite_in = 0; ALU_result_in = 0; EX_MEM_RegisterRd_in = 0;
    cyc();
    rst = 1;
    sample();
    chk("post_rst_req", 32'(dmem_req), 0);
    cyc();
    sample();
    chk("late_ack_req", 32'(dmem_req), 0);
    chk("late_ack_stall", 32'(mem_stall), 0);
    cyc();
    clear();

`ifdef MEM_TIMEOUT_EN
    // Timeout without ack
    run_access(1, 0, 1, 1, 5'd3, 32'h0000_0300, 32'h0, 32'h7777_7777, 4, 0, 32'h0);
    sample();
    chk("to_err", 32'(mem_error), 1);
    cyc();
    sample();
    chk("to_err_sticky", 32'(mem_error), 1);
    #2;
    rst = 0;
    #1;
    chk("to_err_rst", 32'(mem_error), 0);
    cyc();
    rst = 1;
    // Ack on the timeout edge wins
    run_access(1, 0, 1, 1, 5'd4, 32'h0000_0310, 32'h0, 32'h8888_9999, 4, 1, 32'h8888_9999);
    sample();
    chk("to_ack_err", 32'(mem_error), 0);
`else
    // Long wait never times out
    run_access(1, 0, 1, 1, 5'd3, 32'h0000_0300, 32'h0, 32'h7777_7777, 10, 1, 32'h7777_7777);
    sample();
    chk("no_to_err", 32'(mem_error), 0);
`endif

    repeat (3) sample();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the EX/MEM pipeline register in the 5-stage MIPS core. Takes the EX_MEM outputs and resolves branch/jump redirects.
- Performs data-memory reads and writes over a req/ack handshake and stalls the upstream pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register that feeds writeback.

Parameters:
- DATA_W, 32, datapath and address width.
- RD_W, 5, destination register index width.
- TIMEOUT_CYCLES, 64, BUSY cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low; asserted when 0.
- RegWrite_in, MemtoReg_in  input  1 each  writeback controls from EX_MEM.
- Branch_in, MemRead_in, MemWrite_in, Jump_in  input  1 each  MEM controls from EX_MEM.
- jump_addr_in, branch_addr_in  input  DATA_W  redirect targets.
- ALU_zero_in  input  1  branch condition.
- ALU_result_in  input  DATA_W  memory address, or writeback data.
- reg_read_data_2_in  input  DATA_W  store data.
- EX_MEM_RegisterRd_in  input  RD_W  destination register.
- pc_redirect  output  1  combinational: (Branch_in & ALU_zero_in) | Jump_in.
- pc_target  output  DATA_W  combinational: Jump_in ? jump_addr_in : branch_addr_in.
- mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX_MEM.
- dmem_req  output  1  access request.
- dmem_we  output  1  1 = write.
- dmem_addr  output  DATA_W  {ALU_result_in[31:2], 2'b00}.
- dmem_wdata  output  DATA_W  reg_read_data_2_in.
- dmem_ack  input  1  memory completes the access this cycle.
- dmem_rdata  input  DATA_W  read data; valid when dmem_ack=1.
- RegWrite_out, MemtoReg_out  output  1 each  MEM/WB register.
- read_data_out, ALU_result_out  output  DATA_W  MEM/WB register.
- MEM_WB_RegisterRd_out  output  RD_W  MEM/WB register.
- mem_error  output  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, async): state=IDLE; dmem_req=0; dmem_we=0; hold register=0; all MEM/WB outputs=0; mem_error=0. A reset during BUSY drops dmem_req immediately, and any late dmem_ack is ignored.
- access = MemRead_in | MemWrite_in. If both are set, it is a write; read_data_out=0.
- FSM states are IDLE, BUSY and DONE.
- IDLE, access=0:
  - mem_stall=0.
  - MEM/WB loads inputs at the next edge: read_data_out=0, ALU_result_out=ALU_result_in.
  - Latency is 1 cycle.
- IDLE, access=1:
  - mem_stall=1.
  - Next state BUSY; dmem_we registered from MemWrite_in.
  - MEM/WB loads a bubble (all fields 0).
- BUSY:
  - dmem_req=1; mem_stall=1.
  - dmem_addr and dmem_wdata are stable because upstream is frozen.
  - Each edge with dmem_ack=0: stay in BUSY and load a bubble into MEM/WB.
  - Edge with dmem_ack=1: capture dmem_rdata into the hold register (0 for writes), go to DONE, load a bubble.
- DONE:
  - mem_stall=0; dmem_req=0.
  - At the edge, MEM/WB loads the controls, ALU_result_in, Rd and the hold register into read_data_out. State returns to IDLE and EX_MEM advances on the same edge.
  - Minimum access occupancy is 3 cycles (IDLE, BUSY, DONE). A back-to-back access re-enters BUSY via IDLE.
- dmem_ack outside BUSY is ignored.
- dmem_req never asserts for a non-access instruction.
- Stall behaviour: MEM/WB never duplicates an instruction. Every stalled edge writes a bubble: RegWrite_out=0, MemtoReg_out=0, Rd=0, data=0.
- pc_redirect and pc_target are purely combinational and unaffected by stall. The hazard unit qualifies them with mem_stall.
- Stores write back nothing beyond what RegWrite_in specifies; the block passes RegWrite_in through unchanged.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: a counter clears on entry to BUSY and increments each BUSY cycle without ack. When it reaches TIMEOUT_CYCLES, the FSM goes to DONE with hold register=0 and sets mem_error (sticky until rst). A dmem_ack on that same edge takes priority: normal completion, no error.
- Undefined: BUSY waits indefinitely; mem_error is tied to 0; no counter logic.

Test Plan:
- Reset: drive rst=0 mid-BUSY with dmem_req=1 -> dmem_req, mem_stall and all outputs are 0 immediately. After rst=1, state is IDLE and no request issues without access.
- ALU op: RegWrite_in=1, ALU_result_in=32'h0000_1234, Rd=5, no access -> next edge RegWrite_out=1, ALU_result_out=32'h1234, MEM_WB_RegisterRd_out=5, mem_stall=0 throughout.
- Load, ack after 3 BUSY cycles: MemRead_in=1, MemtoReg_in=1, ALU_result_in=32'h0000_0103, dmem_rdata=32'hCAFE_F00D:
  - dmem_addr=32'h100 and dmem_we=0.
  - mem_stall is high for 4 cycles, with bubbles in MEM/WB.
  - Then read_data_out=32'hCAFEF00D, Rd is correct, and dmem_req is 0 in DONE.
- Store, immediate ack: MemWrite_in=1, reg_read_data_2_in=32'hA5A5_A5A5 -> dmem_we=1 and dmem_wdata=32'hA5A5A5A5 during the single BUSY cycle. DONE next, then IDLE. RegWrite_out follows RegWrite_in (0).
- Redirect: Branch_in=1, ALU_zero_in=1, branch_addr_in=32'h40 -> pc_redirect=1, pc_target=32'h40. With Jump_in=1 and jump_addr_in=32'h80, pc_target=32'h80 regardless of ALU_zero_in.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never asserted -> DONE after 4 BUSY cycles, read_data_out=0, mem_error=1 and stays 1 until rst=0. Repeat with ack on the 4th cycle -> mem_error stays 0.
